// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and constants.
// Used by the writeback stage and the register file.
package riscv_pkg;
  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_mux.sv
// Writeback value select: load data or ALU result.
module wb_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [XLEN-1:0] result,
  input  logic            memtoreg,
  output logic [XLEN-1:0] wb_data
);
  assign wb_data = memtoreg ? read_data : result;
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 32-entry integer register file with two
// combinational read ports, same-cycle write-through bypass and a commit counter.
module wb_regfile
  import riscv_pkg::reg_addr_t;
  import riscv_pkg::REG_ZERO;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  wb_read_data,
  input  logic [XLEN-1:0]  wb_result,
  input  reg_addr_t        wb_rd,
  input  logic             wb_memtoreg,
  input  logic             wb_regwrite,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_we,
  output logic [CNT_W-1:0] commit_count
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [CNT_W-1:0] commit_count_q;
  logic [CNT_W-1:0] commit_count_d;

  wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .read_data (wb_read_data),
    .result    (wb_result),
    .memtoreg  (wb_memtoreg),
    .wb_data   (wb_data)
  );

  // Reset suppresses the write so an in-flight commit on the reset edge is lost.
  assign wb_we = wb_regwrite & (wb_rd != REG_ZERO) & ~reset;

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
    end else if (wb_we) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  always_comb begin
    commit_count_d = commit_count_q;
    if (reset)
      commit_count_d = '0;
    else if (wb_we)
      commit_count_d = commit_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    regs_q         <= regs_d;
    commit_count_q <= commit_count_d;
  end

  // Each read port resolves independently: x0, then bypass, then array.
  always_comb begin
    rs1_data = '0;
    if (!reset && rs1_addr != REG_ZERO) begin
      if (wb_we && wb_rd == rs1_addr)
        rs1_data = wb_data;
      else
        rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (!reset && rs2_addr != REG_ZERO) begin
      if (wb_we && wb_rd == rs2_addr)
        rs2_data = wb_data;
      else
        rs2_data = regs_q[rs2_addr];
    end
  end

  assign commit_count = commit_count_q;

endmodule
